// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Code values feed an external hex/segment decoder.
package display_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_DP   = 4'd10;
  localparam logic [CODE_W-1:0] CODE_LAMP = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SHOW
  } scan_state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_phase_counter.sv
// Loadable down-counter; terminal count when it reaches zero.
// Shared by the guard and dwell phases of the scan FSM.
module scan_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode digit scanner with guard gaps and
// frame-boundary commit of host updates.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [CODE_W*NUM_DIGITS-1:0] load_codes,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  output logic [CODE_W-1:0]            dig_code,
  output logic [NUM_DIGITS-1:0]        anode_n,
  output logic                         frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW =
    $clog2(max2(DWELL_CYCLES, GUARD_CYCLES) + 1);

  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] G_LD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] D_LD = CW'(DWELL_CYCLES - 1);

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  frame_t                active_q, active_d;
  frame_t                pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  fd_q, fd_d;

  logic                  ld;
  logic [CW-1:0]         ld_val;
  logic                  tc;
  logic                  commit;
  logic [NUM_DIGITS-1:0] lit_n;

  scan_phase_counter #(
    .W (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .tc_o   (tc)
  );

  // Blank mask is applied live, one register stage ahead of the pin.
  always_comb begin
    lit_n        = '1;
    lit_n[idx_q] = blank_mask[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    anode_d  = '1;
    code_d   = code_q;
    fd_d     = 1'b0;
    ld       = 1'b0;
    ld_val   = '0;
    commit   = 1'b0;

    if (load_valid && !pflag_q) begin
      pend_d  = load_codes;
      pflag_d = 1'b1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      ld      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_GUARD;
          idx_d   = '0;
          ld      = 1'b1;
          ld_val  = G_LD;
        end
        ST_GUARD: begin
          if (tc) begin
            state_d = ST_SHOW;
            ld      = 1'b1;
            ld_val  = D_LD;
            anode_d = lit_n;
          end
        end
        ST_SHOW: begin
          if (tc) begin
            state_d = ST_GUARD;
            ld      = 1'b1;
            ld_val  = G_LD;
            if (idx_q == LAST) begin
              idx_d  = '0;
              fd_d   = 1'b1;
              commit = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            anode_d = lit_n;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_q == ST_IDLE && pflag_q) begin
      commit = 1'b1;
    end

    if (commit) begin
      active_d = pend_q;
      pflag_d  = 1'b0;
    end

    // Code is latched on guard entry from the frame about to be shown.
    if (state_d == ST_GUARD && state_q != ST_GUARD) begin
      code_d = active_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      active_q <= '0;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      anode_q  <= '1;
      code_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      anode_q  <= anode_d;
      code_q   <= code_d;
      fd_q     <= fd_d;
    end
  end

  assign load_ready = !pflag_q;
  assign dig_code   = code_q;
  assign anode_n    = anode_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected digit slots are
// queued with the stimulus and matched against observed anode runs.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_codes = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dig_code;
  logic [3:0]  anode_n;
  logic        frame_done;

  display_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (D),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_codes (load_codes),
    .blank_mask (blank_mask),
    .dig_code   (dig_code),
    .anode_n    (anode_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic [7:0] len;
    logic [7:0] gap;
  } slot_t;

  slot_t exp_q[$];

  task automatic push_slot(input logic [3:0] an, input logic [3:0] code,
                           input int len, input int gap);
    slot_t s;
    s.an   = an;
    s.code = code;
    s.len  = 8'(len);
    s.gap  = 8'(gap);
    exp_q.push_back(s);
  endtask

  task automatic push_frame(input logic [15:0] codes,
                            input logic [3:0] mask,
                            input int first_gap);
    logic [3:0] one;
    int g;
    one = 4'b0001;
    g = first_gap;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        g += D + G;
      end else begin
        push_slot(~(one << i), codes[4*i +: 4], D, g);
        g = G;
      end
    end
  endtask

  // Monitor: collapse each low anode run into one observed slot.
  logic       in_run = 1'b0;
  logic       run_ok;
  logic       ended;
  logic       exp_fd;
  logic [3:0] run_an, run_code;
  int         run_len, run_gap;
  int         gap = 0;
  int         cyc = 0;
  int         fd_prev = -1;
  slot_t      e;

  always @(negedge clk) begin
    cyc++;
    ended = 1'b0;
    if (anode_n !== 4'hF) begin
      if (!in_run) begin
        in_run   = 1'b1;
        run_an   = anode_n;
        run_code = dig_code;
        run_len  = 1;
        run_gap  = gap;
        run_ok   = ($countones(~anode_n) == 1);
      end else begin
        run_len++;
        if (anode_n !== run_an || dig_code !== run_code)
          run_ok = 1'b0;
      end
    end else begin
      if (in_run) begin
        in_run = 1'b0;
        ended  = 1'b1;
        check("slot_stable", 32'(run_ok), 1);
        if (exp_q.size() == 0) begin
          check("slot_unexpected", 32'(run_an), 4'hF);
        end else begin
          e = exp_q.pop_front();
          check("slot_anode", 32'(run_an), 32'(e.an));
          check("slot_code", 32'(run_code), 32'(e.code));
          check("slot_len", 32'(run_len), 32'(e.len));
          check("slot_gap", 32'(run_gap), 32'(e.gap));
        end
      end
      gap = enable ? (ended ? 1 : gap + 1) : 0;
    end
    exp_fd = ended && run_an == 4'b0111 && run_len == D;
    if (frame_done || exp_fd) begin
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (frame_done) begin
        check("fd_load_ready", 32'(load_ready), 1);
        if (fd_prev >= 0)
          check("frame_period", 32'(cyc - fd_prev), N * (D + G));
        fd_prev = cyc;
      end
    end
    if (!enable) fd_prev = -1;
  end

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain_left", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic wait_size(input int n, input int limit);
    int k;
    k = 0;
    while (exp_q.size() > n && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_size", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic wait_anode(input logic [3:0] pat, input int limit);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (anode_n !== pat && k < limit);
    check("anode_seen", 32'(anode_n), 32'(pat));
  endtask

  task automatic start_scan();
    @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  task automatic stop_scan();
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] F0 = 16'hA321;
  localparam logic [15:0] F1 = 16'h5678;
  localparam logic [15:0] F2 = 16'h4C09;

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_anode", 32'(anode_n), 4'hF);
    check("rst_code", 32'(dig_code), 0);
    check("rst_ready", 32'(load_ready), 1);
    check("rst_fd", 32'(frame_done), 0);

    // Free-running scan of an all-zero frame.
    push_frame(16'h0, 4'h0, G + 1);
    push_frame(16'h0, 4'h0, G);
    start_scan();
    drain(200);
    stop_scan();

    // Mid-frame load; commits only at the wrap.
    push_frame(16'h0, 4'h0, G + 1);
    push_frame(F0, 4'h0, G);
    start_scan();
    wait_size(7, 100);
    load_codes = F0;
    load_valid = 1'b1;
    check("ld_ready_pre", 32'(load_ready), 1);
    @(posedge clk);
    #1;
    check("ld_ready_drop", 32'(load_ready), 0);
    load_codes = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 load_valid = 1'b0;
    check("ld_ready_held", 32'(load_ready), 0);
    drain(200);
    stop_scan();

    // Valid held across two frames: one transfer per boundary.
    push_frame(F0, 4'h0, G + 1);
    push_frame(F1, 4'h0, G);
    push_frame(F2, 4'h0, G);
    start_scan();
    wait_size(11, 100);
    load_codes = F1;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_codes = F2;
    check("hold_ready_drop", 32'(load_ready), 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!load_ready && k < 100);
    check("hold_xfer_at_wrap", 32'(frame_done), 1);
    @(posedge clk);
    #1;
    check("hold_ready_drop2", 32'(load_ready), 0);
    load_valid = 1'b0;
    drain(300);
    stop_scan();

    // Blanked digit keeps its slot timing.
    blank_mask = 4'b0100;
    push_frame(F2, 4'b0100, G + 1);
    push_frame(F2, 4'b0100, G);
    start_scan();
    drain(200);
    stop_scan();
    blank_mask = 4'b0000;

    // Disable during SHOW of digit 1, then restart from digit 0.
    push_slot(4'b1110, F2[3:0], D, G + 1);
    push_slot(4'b1101, F2[7:4], 2, G);
    start_scan();
    wait_size(1, 100);
    wait_anode(4'b1101, 50);
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    check("dis_last_low", 32'(anode_n), 4'b1101);
    @(negedge clk);
    check("dis_anode_off", 32'(anode_n), 4'hF);
    repeat (3) @(negedge clk);
    check("dis_stays_off", 32'(anode_n), 4'hF);
    drain(10);
    push_frame(F2, 4'h0, G + 1);
    start_scan();
    drain(100);
    stop_scan();

    // Asynchronous reset mid-SHOW with a pending frame.
    push_slot(4'b1110, F2[3:0], 2, G + 1);
    start_scan();
    wait_anode(4'b1110, 50);
    load_codes = 16'h1234;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    check("rst_pend_ready", 32'(load_ready), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_anode", 32'(anode_n), 4'hF);
    check("arst_ready", 32'(load_ready), 1);
    check("arst_code", 32'(dig_code), 0);
    check("arst_fd", 32'(frame_done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_after", 32'(load_ready), 1);
    push_frame(16'h0, 4'h0, G + 1);
    enable = 1'b1;
    drain(100);
    stop_scan();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
